// File: rtl/io_input_debounce.sv
// rtl/io_input_debounce.sv - debouncer for IO-board buttons and DIP switches
// Buttons report press/release pulses; DIP changes are flagged with a coalescing valid/ready flag.
module io_input_debounce #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  io_button,
  input  logic [23:0] io_dip,
  output logic [4:0]  btn_state,
  output logic [4:0]  btn_press,
  output logic [4:0]  btn_release,
  output logic [23:0] dip_state,
  output logic        dip_valid,
  input  logic        dip_ready
);

  localparam int N_IN = 29;
  localparam int N_BTN = 5;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [N_IN-1:0] deb;
  logic [N_IN-1:0] deb_next;
  logic [CW-1:0]   cnt      [N_IN];
  logic [CW-1:0]   cnt_next [N_IN];
  logic            dip_change;

  assign tick = (presc == TICK_LAST);

  // Counters only ever reach CNT_LAST; the toggle clears them, so they never wrap.
  always_comb begin
    deb_next = deb;
    for (int i = 0; i < N_IN; i++) begin
      cnt_next[i] = cnt[i];
      if (tick) begin
        if (sync2[i] == deb[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb_next[i] = ~deb[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign dip_change = (deb_next[N_IN-1:N_BTN] != deb[N_IN-1:N_BTN]);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      presc       <= '0;
      deb         <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      dip_valid   <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= {io_dip, io_button};
      sync2 <= sync1;
      presc <= tick ? '0 : presc + PW'(1);
      deb   <= deb_next;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= cnt_next[i];
      end
      // Pulses are registered alongside the state so they line up with its first new cycle.
      btn_press   <= deb_next[N_BTN-1:0] & ~deb[N_BTN-1:0];
      btn_release <= ~deb_next[N_BTN-1:0] & deb[N_BTN-1:0];
      // A change landing on the handshake edge keeps the flag set so it is not lost.
      dip_valid   <= dip_change | (dip_valid & ~dip_ready);
    end
  end

  assign btn_state = deb[N_BTN-1:0];
  assign dip_state = deb[N_IN-1:N_BTN];

endmodule

// File: tb/tb_io_input_debounce.sv
// tb/tb_io_input_debounce.sv - randomized and directed bench for io_input_debounce
// Checks outputs every cycle against a tick-count model, plus literal scenario expectations.
module tb_io_input_debounce;

  localparam int TD = 4;
  localparam int ST = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  io_button;
  logic [23:0] io_dip;
  logic [4:0]  btn_state;
  logic [4:0]  btn_press;
  logic [4:0]  btn_release;
  logic [23:0] dip_state;
  logic        dip_valid;
  logic        dip_ready;

  io_input_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk),
    .reset(reset),
    .io_button(io_button),
    .io_dip(io_dip),
    .btn_state(btn_state),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .dip_state(dip_state),
    .dip_valid(dip_valid),
    .dip_ready(dip_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit compare_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset, raw samples delayed two edges, run length of mismatching ticks.
  logic [28:0] m_d1, m_d2, m_deb;
  logic [4:0]  m_press, m_release;
  logic        m_valid;
  int          m_run [29];
  int          m_k;

  always @(posedge clk) begin : model
    logic [28:0] raw, nxt;
    raw = {io_dip, io_button};
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_deb = '0;
      m_press = '0; m_release = '0; m_valid = 1'b0;
      m_k = 0;
      for (int i = 0; i < 29; i++) m_run[i] = 0;
    end else begin
      m_k++;
      nxt = m_deb;
      if (m_k % TD == 0) begin
        for (int i = 0; i < 29; i++) begin
          if (m_d2[i] == m_deb[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              nxt[i] = ~m_deb[i];
              m_run[i] = 0;
            end
          end
        end
      end
      m_press   = nxt[4:0] & ~m_deb[4:0];
      m_release = ~nxt[4:0] & m_deb[4:0];
      m_valid   = (nxt[28:5] != m_deb[28:5]) || (m_valid && !dip_ready);
      m_deb = nxt;
      m_d2 = m_d1;
      m_d1 = raw;
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      chk("btn_state", btn_state, m_deb[4:0]);
      chk("btn_press", btn_press, m_press);
      chk("btn_release", btn_release, m_release);
      chk("dip_state", dip_state, m_deb[28:5]);
      chk("dip_valid", dip_valid, m_valid);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits up to n cycles for any bit of the selected pulse, returning the first nonzero value.
  task automatic wait_pulse(input bit rel, input int n, output logic [4:0] seen);
    seen = '0;
    for (int c = 0; c < n && seen == 0; c++) begin
      @(negedge clk);
      seen = rel ? btn_release : btn_press;
    end
  endtask

  initial begin
    int lat, presses, rels;
    bit found;
    logic [4:0] seen;

    reset = 1'b1; io_button = '0; io_dip = '0; dip_ready = 1'b0;
    cyc(3);
    compare_on = 1;
    chk("reset_btn_state", btn_state, 5'd0);
    chk("reset_dip_state", dip_state, 24'd0);
    chk("reset_dip_valid", dip_valid, 1'b0);
    reset = 1'b0;
    cyc(2);

    // Clean press on button 0
    lat = -1; presses = 0; rels = 0;
    io_button[0] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (btn_state[0] && lat < 0) lat = c;
      presses += int'(btn_press[0]);
      rels += int'(btn_release[0]);
    end
    chk("s31_latency_le_15", (lat > 0 && lat <= 15), 1'b1);
    chk("s31_press_count", presses, 1);
    chk("s31_release_count", rels, 0);

    // Bouncing button 2: toggles every 5 cycles never span three ticks
    presses = 0; rels = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) io_button[2] = ~io_button[2];
      @(negedge clk);
      presses += int'(btn_press[2]);
      rels += int'(btn_release[2]);
    end
    chk("s32_bounce_press", presses, 0);
    chk("s32_bounce_release", rels, 0);
    io_button[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      presses += int'(btn_press[2]);
    end
    chk("s32_hold_press", presses, 1);
    io_button = '0;
    cyc(25);

    // DIP change with consumer stalled, then one-cycle handshake
    io_dip = 24'hA5A5A5;
    cyc(25);
    chk("s33_dip_state", dip_state, 24'hA5A5A5);
    chk("s33_valid_held", dip_valid, 1'b1);
    dip_ready = 1'b1;
    @(negedge clk);
    dip_ready = 1'b0;
    chk("s33_valid_cleared", dip_valid, 1'b0);

    // Coalescing while pending
    io_dip = 24'hA5A5A7;
    cyc(25);
    io_dip = 24'h000001;
    cyc(25);
    chk("s34_coalesced_state", dip_state, 24'h000001);
    chk("s34_valid_pending", dip_valid, 1'b1);
    // Handshake on the edge that makes dip bit 1 visible
    io_dip = 24'h000003;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (((m_k + 1) % TD == 0) && (m_d2[6] != m_deb[6]) && (m_run[6] == ST - 1)) begin
        found = 1;
        dip_ready = 1'b1;
        @(negedge clk);
        dip_ready = 1'b0;
        chk("s34_coincident_valid", dip_valid, 1'b1);
        chk("s34_coincident_state", dip_state, 24'h000003);
      end
    end
    chk("s34_coincident_found", found, 1'b1);
    dip_ready = 1'b1;
    @(negedge clk);
    dip_ready = 1'b0;
    chk("s34_final_clear", dip_valid, 1'b0);

    // Simultaneous press/release on buttons 1 and 4
    io_button = 5'b10010;
    wait_pulse(1'b0, 30, seen);
    chk("s35_press_vec", seen, 5'b10010);
    @(negedge clk);
    chk("s35_press_one_cycle", btn_press, 5'b00000);
    io_button = 5'b00000;
    wait_pulse(1'b1, 30, seen);
    chk("s35_release_vec", seen, 5'b10010);
    cyc(5);

    // Reset during qualification of button 3
    io_button[3] = 1'b1;
    cyc(6);
    reset = 1'b1;
    @(negedge clk);
    chk("s36_btn_state", btn_state, 5'd0);
    chk("s36_btn_press", btn_press, 5'd0);
    chk("s36_btn_release", btn_release, 5'd0);
    chk("s36_dip_state", dip_state, 24'd0);
    chk("s36_dip_valid", dip_valid, 1'b0);
    io_button[3] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    presses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      presses += (btn_press != 0) ? 1 : 0;
    end
    chk("s36_no_press", presses, 0);
    // DIP held high through reset requalifies
    chk("s30_dip_requalified", dip_state, 24'h000003);
    chk("s30_dip_valid", dip_valid, 1'b1);
    dip_ready = 1'b1;
    @(negedge clk);
    dip_ready = 1'b0;

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) io_button[$urandom_range(0, 4)] ^= 1'b1;
      if ($urandom_range(0, 11) == 0) io_dip[$urandom_range(0, 23)] ^= 1'b1;
      dip_ready = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
